// File: rtl/id_inst_buffer_if.sv
// Handshake bundle between IF, the instruction buffer and ID.
// master = IF/ID side, slave = id_inst_buffer.
interface id_inst_buffer_if #(
  parameter int DEPTH   = 4,
  parameter int PC_WD   = 32,
  parameter int INST_WD = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               req_valid;
  logic [PC_WD-1:0]   req_pc;
  logic               fetch_ready;
  logic [INST_WD-1:0] inst_sram_rdata;
  logic               out_valid;
  logic [PC_WD-1:0]   out_pc;
  logic [INST_WD-1:0] out_inst;
  logic               out_ready;
  logic               flush;
  logic               keep_one;
  logic [CW-1:0]      count;

  modport master (
    output req_valid, req_pc, inst_sram_rdata, out_ready, flush, keep_one,
    input  fetch_ready, out_valid, out_pc, out_inst, count
  );

  modport slave (
    input  req_valid, req_pc, inst_sram_rdata, out_ready, flush, keep_one,
    output fetch_ready, out_valid, out_pc, out_inst, count
  );
endinterface

// File: rtl/id_inst_buffer.sv
// IF->ID instruction buffer: pairs each SRAM response with its fetch PC and queues
// DEPTH {pc, inst} entries with branch flush. Define IBUF_BYPASS_EN for empty-buffer bypass.
module id_inst_buffer #(
  parameter int DEPTH   = 4,
  parameter int PC_WD   = 32,
  parameter int INST_WD = 32
) (
  input  logic             clk,
  input  logic             rst,
  id_inst_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [PC_WD-1:0]   mem_pc_q   [DEPTH];
  logic [INST_WD-1:0] mem_inst_q [DEPTH];

  logic [AW-1:0]    rp_q, rp_d;
  logic [AW-1:0]    wp_q, wp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pend_q, pend_d;
  logic [PC_WD-1:0] pend_pc_q, pend_pc_d;

  logic             byp_hit;
  logic             pop_buf;
  logic             pop_byp;
  logic             arrive;
  logic             wr_en;
  logic             fetch_ok;
  logic [CW-1:0]    cnt_left;

  always_comb begin
`ifdef IBUF_BYPASS_EN
    byp_hit = (count_q == '0) && pend_q && !(bus.flush && !bus.keep_one);
`else
    byp_hit = 1'b0;
`endif

    bus.out_valid = (count_q != '0) || byp_hit;
`ifdef IBUF_BYPASS_EN
    bus.out_pc    = byp_hit ? pend_pc_q : mem_pc_q[rp_q];
    bus.out_inst  = byp_hit ? bus.inst_sram_rdata : mem_inst_q[rp_q];
`else
    bus.out_pc    = mem_pc_q[rp_q];
    bus.out_inst  = mem_inst_q[rp_q];
`endif
    bus.count     = count_q;

    // A pop in this cycle deliberately grants no fetch credit.
    fetch_ok        = ((CW+1)'(count_q) + (CW+1)'(pend_q)) < DEPTH_W;
    bus.fetch_ready = fetch_ok;

    pop_buf  = (count_q != '0) && bus.out_ready;
    pop_byp  = byp_hit && bus.out_ready;
    rp_d     = rp_q + AW'(pop_buf);
    cnt_left = count_q - CW'(pop_buf);
    arrive   = pend_q && !pop_byp;

    wr_en   = 1'b0;
    wp_d    = wp_q;
    count_d = cnt_left;

    // Flush resolves after the pop; keep_one falls through to a normal push
    // when only the arriving response is left to keep.
    if (bus.flush && !bus.keep_one) begin
      count_d = '0;
      wp_d    = rp_d;
    end else if (bus.flush && bus.keep_one && (cnt_left != '0)) begin
      count_d = CW'(1);
      wp_d    = rp_d + AW'(1);
    end else if (arrive) begin
      wr_en   = 1'b1;
      wp_d    = wp_q + AW'(1);
      count_d = cnt_left + CW'(1);
    end

    pend_d    = bus.req_valid && fetch_ok;
    pend_pc_d = pend_d ? bus.req_pc : pend_pc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rp_q      <= '0;
      wp_q      <= '0;
      count_q   <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      rp_q      <= rp_d;
      wp_q      <= wp_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Entry storage is not reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem_pc_q[wp_q]   <= pend_pc_q;
      mem_inst_q[wp_q] <= bus.inst_sram_rdata;
    end
  end
endmodule
